// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default widths, wait-counter width,
// request control encodings shared with the CU-side interface block, and FSM states.
package mem_responder_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W      = 4;

   // req_write encoding, identical to the interface block's ctrl bit
   localparam logic CTRL_READ  = 1'b0;
   localparam logic CTRL_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM: one write port, registered read, no reset.
// Ports:
//   clk    - rising-edge clock
//   wr_en  - write data to addr this edge
//   rd_en  - load rdata from addr this edge (rdata holds otherwise)
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data
module mem_responder_array #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wdata;
      end
      if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the CPU memory interface. Accepts one request at a time,
// commits writes immediately and returns read data after RD_LAT cycles.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_write             - CTRL_WRITE = write, CTRL_READ = read
//   req_addr, req_wdata   - word address and write data
//   rsp_valid/rsp_ready   - response handshake, rsp_data holds the read word
//   addr_err              - one-cycle pulse for an accepted out-of-range request
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_ready,
   output logic              addr_err
);

   localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   state_e             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               oor, oor_next;
   logic               req_ready_next;
   logic               rsp_valid_next;
   logic [DATA_W-1:0]  rsp_data_next;
   logic               addr_err_next;
   logic               accept;
   logic               in_range;
   logic               wr_en;
   logic               rd_en;
   logic [DATA_W-1:0]  rdata;

   assign accept   = req_valid & req_ready;
   // Full-width compare: addresses are never wrapped into the array.
   assign in_range = ({1'b0, req_addr} < DEPTH_V);

   mem_responder_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk    (clk),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .addr   (IDX_W'(req_addr)),
      .wdata  (req_wdata),
      .rdata  (rdata)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         oor       <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         addr_err  <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         oor       <= oor_next;
         req_ready <= req_ready_next;
         rsp_valid <= rsp_valid_next;
         rsp_data  <= rsp_data_next;
         addr_err  <= addr_err_next;
      end
   end

   // Next-state, wait counter, array strobes and response capture
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      oor_next       = oor;
      rsp_valid_next = rsp_valid;
      rsp_data_next  = rsp_data;
      addr_err_next  = 1'b0;
      wr_en          = 1'b0;
      rd_en          = 1'b0;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               addr_err_next = ~in_range;
               if (req_write == CTRL_WRITE) begin
                  wr_en = in_range;
               end else begin
                  // Registered array read lands after this edge, so even
                  // RD_LAT==1 spends one cycle in WAIT with the counter at 0.
                  rd_en      = 1'b1;
                  oor_next   = ~in_range;
                  cnt_next   = LAT_LOAD;
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               state_next     = ST_RESP;
               rsp_valid_next = 1'b1;
               rsp_data_next  = oor ? '0 : rdata;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b0;
            end
         end
         default: begin
            state_next     = ST_IDLE;
            rsp_valid_next = 1'b0;
         end
      endcase

      // Ready is registered; it reopens the cycle after the response handshake.
      req_ready_next = (state_next == ST_IDLE);
   end

endmodule
